// File: rtl/tick_gen.sv
// tick_gen: multi-channel clock-enable generator with runtime-programmable dividers.
// Ports: clk, rst (async, high); en, ch_en[CHANNELS], sync_restart;
//        cfg_we, cfg_ch, cfg_div, cfg_oneshot write port;
//        tick/level/done per channel, all registered.
module tick_gen #(
  parameter int CHANNELS = 4,
  parameter int DIV_W = 16,
  parameter int unsigned DEFAULT_DIV = 1,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                sync_restart,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                cfg_oneshot,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] done
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_os;
    logic             r_tick;
    logic             r_level;
    logic             r_done;
    logic             w_sel;
    logic             w_act;
    logic             w_tc;

    // Out-of-range cfg_ch never equals any g, so such writes fall away.
    assign w_sel = cfg_we && (int'(cfg_ch) == g);
    assign w_act = en && ch_en[g] && !r_done;
    // cnt only counts up to div, so it cannot wrap even for all-ones div.
    assign w_tc  = (r_cnt == r_div);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_div   <= RST_DIV;
        r_cnt   <= '0;
        r_os    <= 1'b0;
        r_tick  <= 1'b0;
        r_level <= 1'b0;
        r_done  <= 1'b0;
      end else if (sync_restart) begin
        r_cnt   <= '0;
        r_tick  <= 1'b0;
        r_level <= 1'b0;
        r_done  <= 1'b0;
        // A write on the restart edge still lands its configuration.
        if (w_sel) begin
          r_div <= cfg_div;
          r_os  <= cfg_oneshot;
        end
      end else if (w_sel) begin
        r_div  <= cfg_div;
        r_os   <= cfg_oneshot;
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_done <= 1'b0;
      end else if (w_act) begin
        if (w_tc) begin
          r_cnt   <= '0;
          r_tick  <= 1'b1;
          r_level <= ~r_level;
          if (r_os) r_done <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
          r_tick <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
      end
    end

    assign tick[g]  = r_tick;
    assign level[g] = r_level;
    assign done[g]  = r_done;
  end

endmodule
